apb_master_arbiter: RTL and testbench

- Shares a single APB master port between NUM_REQ internal requesters.
- Round-robin arbitration selects one requester at a time.
- Each granted request is sequenced through the APB SETUP and ACCESS phases, and the response is returned to the requester that issued it.
- Sits between CPU/DMA-side request ports and the APB bus, upstream of the slave address decoder. A programmable timeout terminates transfers that hang.

---
 rtl/apb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/apb_master_arbiter.sv | 110 +++++++++++
 tb/tb_apb_master_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and helpers for the APB master arbiter
package apb_pkg;
    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    typedef struct packed {
        logic [APB_AW-1:0] addr;
        logic              write;
        logic [APB_DW-1:0] wdata;
    } apb_req_t;

    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    logic [PW-1:0] k;

    // scan from the far end so the request nearest the pointer is assigned last and wins
    always_comb begin
        k   = '0;
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            k = PW'((int'(ptr) + i) % N);
            if (req[k]) begin
                idx = k;
                any = 1'b1;
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port among NUM_REQ requesters with round-robin arbitration
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = APB_DW,
    parameter int ADDR_WIDTH     = APB_AW,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic                          PREADY,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PSLVERR
);
    localparam int PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW       = cnt_width(TIMEOUT_CYCLES);
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    apb_state_e         state, state_nx;
    apb_req_t           req_q;
    logic [PW-1:0]      ptr, gidx, gidx_q;
    logic [NUM_REQ-1:0] gnt;
    logic               any, timeout, done;
    logic [CW-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req (req_valid_i),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (any)
    );

    assign sel_addr  = req_addr_i[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata_i[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];

    // the counter reaches TIMEOUT_CYCLES on this edge; a simultaneous PREADY takes precedence
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TMO_LAST)) && !PREADY;
    assign done    = (state == ACCESS) && (PREADY || timeout);

    assign PADDR  = ADDR_WIDTH'(req_q.addr);
    assign PWRITE = req_q.write;
    assign PWDATA = DATA_WIDTH'(req_q.wdata);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any ? SETUP : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = done ? IDLE : ACCESS;
            default: state_nx = IDLE;
        endcase
    end

    // ready is masked by reset so a pending request is never acknowledged while held in reset
    always_comb begin
        req_ready_o = (state == IDLE && PRESETn) ? gnt : '0;
        PSEL        = state != IDLE;
        PENABLE     = state == ACCESS;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ptr         <= '0;
            gidx_q      <= '0;
            req_q       <= '0;
            cnt         <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= '0;
            if (state == IDLE && any) begin
                gidx_q      <= gidx;
                ptr         <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
                req_q.addr  <= APB_AW'(sel_addr);
                req_q.write <= req_write_i[gidx];
                req_q.wdata <= req_write_i[gidx] ? APB_DW'(sel_wdata) : '0;
                cnt         <= '0;
            end
            if (state == ACCESS && !PREADY) cnt <= cnt + 1'b1;
            if (done) begin
                rsp_valid_o <= NUM_REQ'(1) << gidx_q;
                rsp_err_o   <= PREADY ? PSLVERR : 1'b1;
                rsp_rdata_o <= (PREADY && !req_q.write) ? PRDATA : '0;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed cycle-level checks of arbitration, APB phasing, errors and timeout
module tb_apb_master_arbiter;
    logic        PCLK, PRESETn;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA;
    logic        rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [5:0]  st;
    int          chk_cnt, pass_cnt;

    apb_master_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR)
    );

    assign st = {req_ready, PSEL, PENABLE, rsp_valid};

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic test_reset();
        req_valid = 2'b11;
        repeat (2) @(negedge PCLK);
        #1;
        chk_cnt++;
        if ({st, PADDR, PWRITE, PWDATA, rsp_rdata, rsp_err} !== '0)
            $display("FAIL reset_outputs st=%b paddr=%h pwdata=%h rdata=%h err=%b required all zero", st, PADDR, PWDATA, rsp_rdata, rsp_err);
        else pass_cnt++;
        req_valid = 2'b00;
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        chk_cnt++;
        if (st !== 6'b00_0_0_00) $display("FAIL idle_no_req st=%b required 000000", st);
        else pass_cnt++;
    endtask

    task automatic test_single_write();
        @(negedge PCLK);
        req_valid = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h1000; req_wdata[31:0] = 32'hDEADBEEF; PREADY = 1'b1;
        #1;
        chk_cnt++;
        if (st !== 6'b01_0_0_00) $display("FAIL wr_accept st=%b required 010000", st);
        else pass_cnt++;
        @(negedge PCLK);
        req_valid = 2'b00;
        #1;
        chk_cnt++;
        if ({st, PADDR, PWRITE, PWDATA} !== {6'b00_1_0_00, 32'h1000, 1'b1, 32'hDEADBEEF})
            $display("FAIL wr_setup st=%b paddr=%h pwrite=%b pwdata=%h required 001000 00001000 1 deadbeef", st, PADDR, PWRITE, PWDATA);
        else pass_cnt++;
        @(negedge PCLK);
        #1;
        chk_cnt++;
        if ({st, PADDR, PWRITE, PWDATA} !== {6'b00_1_1_00, 32'h1000, 1'b1, 32'hDEADBEEF})
            $display("FAIL wr_access st=%b paddr=%h pwrite=%b pwdata=%h required 001100 00001000 1 deadbeef", st, PADDR, PWRITE, PWDATA);
        else pass_cnt++;
        @(negedge PCLK);
        #1;
        chk_cnt++;
        if ({st, rsp_err} !== {6'b00_0_0_01, 1'b0}) $display("FAIL wr_rsp st=%b err=%b required 000001 0", st, rsp_err);
        else pass_cnt++;
    endtask

    task automatic test_wait_read();
        @(negedge PCLK);
        req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h2004; PREADY = 1'b0;
        #1;
        chk_cnt++;
        if (st !== 6'b10_0_0_00) $display("FAIL rd_accept st=%b required 100000", st);
        else pass_cnt++;
        @(negedge PCLK);
        req_valid = 2'b00;
        #1;
        chk_cnt++;
        if ({st, PADDR, PWRITE, PWDATA} !== {6'b00_1_0_00, 32'h2004, 1'b0, 32'h0})
            $display("FAIL rd_setup st=%b paddr=%h pwrite=%b pwdata=%h required 001000 00002004 0 00000000", st, PADDR, PWRITE, PWDATA);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            PREADY = (i == 3);
            PRDATA = (i == 3) ? 32'hCAFE0001 : 32'hBAD00000 + 32'(i);
            #1;
            chk_cnt++;
            if (st !== 6'b00_1_1_00) $display("FAIL rd_wait%0d st=%b required 001100", i, st);
            else pass_cnt++;
        end
        @(negedge PCLK);
        PREADY = 1'b0;
        #1;
        chk_cnt++;
        if ({st, rsp_rdata, rsp_err} !== {6'b00_0_0_10, 32'hCAFE0001, 1'b0})
            $display("FAIL rd_rsp st=%b rdata=%h err=%b required 000010 cafe0001 0", st, rsp_rdata, rsp_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] prev;
        logic [31:0] exp_addr;
        PRESETn = 1'b0;
        req_valid = 2'b11; req_write = 2'b11; req_addr = {32'h200, 32'h100}; req_wdata = {32'hB, 32'hA}; PREADY = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b1;
        prev = 2'b00;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge PCLK);
            #1;
            exp_addr = ((c / 3) % 2 == 0) ? 32'h100 : 32'h200;
            chk_cnt++;
            case (c % 3)
                0: if (st !== {2'b01 << ((c / 3) % 2), 2'b00, prev}) $display("FAIL b2b_idle c%0d st=%b required %b", c, st, {2'b01 << ((c / 3) % 2), 2'b00, prev});
                   else pass_cnt++;
                1: if ({st, PADDR} !== {6'b00_1_0_00, exp_addr}) $display("FAIL b2b_setup c%0d st=%b paddr=%h required 001000 %h", c, st, PADDR, exp_addr);
                   else pass_cnt++;
                default: if ({st, PADDR} !== {6'b00_1_1_00, exp_addr}) $display("FAIL b2b_access c%0d st=%b paddr=%h required 001100 %h", c, st, PADDR, exp_addr);
                   else pass_cnt++;
            endcase
            if (c % 3 == 2) prev = 2'b01 << ((c / 3) % 2);
        end
        @(negedge PCLK);
        req_valid = 2'b00;
        #1;
        chk_cnt++;
        if (st !== 6'b00_0_0_10) $display("FAIL b2b_last_rsp st=%b required 000010", st);
        else pass_cnt++;
    endtask

    task automatic test_slave_error();
        @(negedge PCLK);
        req_valid = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h3000; req_wdata[31:0] = 32'h11; PREADY = 1'b1; PSLVERR = 1'b1;
        #1;
        chk_cnt++;
        if (st !== 6'b01_0_0_00) $display("FAIL err_accept st=%b required 010000", st);
        else pass_cnt++;
        @(negedge PCLK);
        req_valid = 2'b00;
        @(negedge PCLK);
        @(negedge PCLK);
        req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h3004; PSLVERR = 1'b0; PRDATA = 32'h1234;
        #1;
        chk_cnt++;
        if ({st, rsp_err, rsp_rdata} !== {6'b10_0_0_01, 1'b1, 32'h0})
            $display("FAIL err_rsp st=%b err=%b rdata=%h required 100001 1 00000000", st, rsp_err, rsp_rdata);
        else pass_cnt++;
        @(negedge PCLK);
        req_valid = 2'b00;
        #1;
        chk_cnt++;
        if ({st, PADDR} !== {6'b00_1_0_00, 32'h3004}) $display("FAIL err_next_setup st=%b paddr=%h required 001000 00003004", st, PADDR);
        else pass_cnt++;
        @(negedge PCLK);
        @(negedge PCLK);
        #1;
        chk_cnt++;
        if ({st, rsp_err, rsp_rdata} !== {6'b00_0_0_10, 1'b0, 32'h1234})
            $display("FAIL err_next_rsp st=%b err=%b rdata=%h required 000010 0 00001234", st, rsp_err, rsp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        for (int r = 0; r < 2; r++) begin
            @(negedge PCLK);
            req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h4000; PREADY = 1'b0; PRDATA = 32'hFFFFFFFF;
            #1;
            chk_cnt++;
            if (st !== 6'b01_0_0_00) $display("FAIL tmo_accept r%0d st=%b required 010000", r, st);
            else pass_cnt++;
            @(negedge PCLK);
            req_valid = 2'b00;
            for (int i = 0; i < 4; i++) begin
                @(negedge PCLK);
                PREADY = (r == 1 && i == 3);
                #1;
                chk_cnt++;
                if (st !== 6'b00_1_1_00) $display("FAIL tmo_access r%0d i%0d st=%b required 001100", r, i, st);
                else pass_cnt++;
            end
            @(negedge PCLK);
            PREADY = 1'b0;
            #1;
            chk_cnt++;
            if ({st, rsp_err, rsp_rdata} !== {6'b00_0_0_01, r == 0, (r == 0) ? 32'h0 : 32'hFFFFFFFF})
                $display("FAIL tmo_rsp r%0d st=%b err=%b rdata=%h required 000001 %b %h", r, st, rsp_err, rsp_rdata, r == 0, (r == 0) ? 32'h0 : 32'hFFFFFFFF);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge PCLK);
        req_valid = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h5000; req_wdata[31:0] = 32'h55; PREADY = 1'b0;
        @(negedge PCLK);
        req_valid = 2'b00;
        @(negedge PCLK);
        #1;
        chk_cnt++;
        if (st !== 6'b00_1_1_00) $display("FAIL rst_pre_access st=%b required 001100", st);
        else pass_cnt++;
        #2;
        PRESETn = 1'b0;
        req_valid = 2'b11;
        #1;
        chk_cnt++;
        if ({st, PADDR} !== '0) $display("FAIL rst_async st=%b paddr=%h required 000000 00000000", st, PADDR);
        else pass_cnt++;
        @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY = 1'b1;
        #1;
        chk_cnt++;
        if (st !== 6'b01_0_0_00) $display("FAIL rst_ptr_zero st=%b required 010000", st);
        else pass_cnt++;
        @(negedge PCLK);
        req_valid = 2'b10;
        @(negedge PCLK);
        @(negedge PCLK);
        #1;
        chk_cnt++;
        if (st !== 6'b10_0_0_01) $display("FAIL rst_then_req1 st=%b required 100001", st);
        else pass_cnt++;
        req_valid = 2'b00;
        repeat (3) @(negedge PCLK);
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        test_reset();
        test_single_write();
        test_wait_read();
        test_back_to_back();
        test_slave_error();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
